// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one bank of JK flip-flops
// between NREQ requesters. At most one command is applied per cycle; grants
// are registered and one-hot.
module jk_bank_arbiter #(
    parameter int               NREQ   = 4,
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] Q_INIT = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   j,
    input  logic [NREQ*WIDTH-1:0]   k,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] last_id,
    output logic                    abort,
    output logic [15:0]             apply_cnt
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic             abort_q, abort_d;
    logic [15:0]      apply_cnt_q, apply_cnt_d;

    logic [WIDTH-1:0] j_lane [NREQ];
    logic [WIDTH-1:0] k_lane [NREQ];
    logic [IDW-1:0]   g_idx;
    logic [NREQ-1:0]  pick;

    // Split the flat J/K buses into per-lane vectors.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign j_lane[gi] = j[gi*WIDTH +: WIDTH];
        assign k_lane[gi] = k[gi*WIDTH +: WIDTH];
    end

    // First set bit of r, searching from base+1 and wrapping; one-hot result.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IDW-1:0]  base);
        logic [NREQ-1:0] oh;
        logic            found;
        logic [IDW-1:0]  idx;
        oh    = '0;
        found = 1'b0;
        for (int n = 1; n <= NREQ; n++) begin
            idx = IDW'((int'(base) + n) % NREQ);
            if (!found && r[idx]) begin
                oh[idx] = 1'b1;
                found   = 1'b1;
            end
        end
        return oh;
    endfunction

    // Encode the registered one-hot grant into a lane index.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) g_idx = IDW'(i);
        end
    end

    // FSM next-state, arbitration and JK bank update.
    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        ptr_d       = ptr_q;
        q_d         = q_q;
        last_id_d   = last_id_q;
        abort_d     = 1'b0;
        apply_cnt_d = apply_cnt_q;
        pick        = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = rr_pick(req, ptr_q);
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                ptr_d = g_idx;
                if (req[g_idx]) begin
                    q_d         = (j_lane[g_idx] & ~q_q) | (~k_lane[g_idx] & q_q);
                    last_id_d   = g_idx;
                    apply_cnt_d = (apply_cnt_q == 16'hFFFF) ? apply_cnt_q
                                                            : apply_cnt_q + 16'd1;
                end else begin
                    abort_d = 1'b1;
                end
                // The lane just served is masked so it cannot be granted twice in a row.
                pick    = rr_pick(req & ~gnt_q, g_idx);
                gnt_d   = pick;
                state_d = (|pick) ? S_GRANT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            q_q         <= Q_INIT;
            last_id_q   <= '0;
            abort_q     <= 1'b0;
            apply_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            q_q         <= q_d;
            last_id_q   <= last_id_d;
            abort_q     <= abort_d;
            apply_cnt_q <= apply_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign q         = q_q;
    assign busy      = (state_q == S_GRANT);
    assign last_id   = last_id_q;
    assign abort     = abort_q;
    assign apply_cnt = apply_cnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (NREQ=4, WIDTH=8, Q_INIT=0).
module tb_jk_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] j;
    logic [31:0] k;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  last_id;
    logic        abort;
    logic [15:0] apply_cnt;

    int vectors;
    int miscompares;

    jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .Q_INIT(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .j         (j),
        .k         (k),
        .gnt       (gnt),
        .q         (q),
        .busy      (busy),
        .last_id   (last_id),
        .abort     (abort),
        .apply_cnt (apply_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        j     = '0;
        k     = '0;

        // 1: reset
        tick();
        tick();
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_gnt", {28'd0, gnt}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_cnt", {16'd0, apply_cnt}, 32'h0);
        chk("rst_abort", {31'd0, abort}, 32'h0);
        chk("rst_last", {30'd0, last_id}, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("idle_gnt", {28'd0, gnt}, 32'h0);

        // 2: lane1 sets all bits
        req = 4'b0010;
        j   = {8'h00, 8'h00, 8'hFF, 8'h00};
        k   = '0;
        tick();
        chk("t2_gnt", {28'd0, gnt}, 32'h2);
        chk("t2_busy", {31'd0, busy}, 32'h1);
        chk("t2_q_pre", {24'd0, q}, 32'h00);
        tick();
        req = 4'b0000;
        chk("t2_q", {24'd0, q}, 32'hFF);
        chk("t2_last", {30'd0, last_id}, 32'h1);
        chk("t2_cnt", {16'd0, apply_cnt}, 32'h1);
        chk("t2_gnt_off", {28'd0, gnt}, 32'h0);
        chk("t2_busy_off", {31'd0, busy}, 32'h0);

        // 3: lane0 toggles low nibble, then lane2 clears high nibble
        req = 4'b0001;
        j   = {8'h00, 8'h00, 8'h00, 8'h0F};
        k   = {8'h00, 8'h00, 8'h00, 8'h0F};
        tick();
        chk("t3a_gnt", {28'd0, gnt}, 32'h1);
        tick();
        req = 4'b0000;
        chk("t3a_q", {24'd0, q}, 32'hF0);
        chk("t3a_last", {30'd0, last_id}, 32'h0);
        req = 4'b0100;
        j   = {8'h00, 8'h00, 8'h00, 8'h00};
        k   = {8'h00, 8'hF0, 8'h00, 8'h00};
        tick();
        chk("t3b_gnt", {28'd0, gnt}, 32'h4);
        tick();
        req = 4'b0000;
        chk("t3b_q", {24'd0, q}, 32'h00);
        chk("t3b_last", {30'd0, last_id}, 32'h2);
        chk("t3b_cnt", {16'd0, apply_cnt}, 32'h3);

        // 4: all lanes from reset, strict rotation
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 4'b1111;
        j   = {8'h08, 8'h04, 8'h02, 8'h01};
        k   = '0;
        tick();
        chk("t4_gnt0", {28'd0, gnt}, 32'h1);
        tick();
        chk("t4_gnt1", {28'd0, gnt}, 32'h2);
        req[0] = 1'b0;
        tick();
        chk("t4_gnt2", {28'd0, gnt}, 32'h4);
        req[1] = 1'b0;
        tick();
        chk("t4_gnt3", {28'd0, gnt}, 32'h8);
        req[2] = 1'b0;
        tick();
        req[3] = 1'b0;
        chk("t4_gnt_off", {28'd0, gnt}, 32'h0);
        chk("t4_busy", {31'd0, busy}, 32'h0);
        chk("t4_q", {24'd0, q}, 32'h0F);
        chk("t4_cnt", {16'd0, apply_cnt}, 32'h4);
        chk("t4_last", {30'd0, last_id}, 32'h3);

        // 5: lane3 drops req in its grant cycle -> abort
        req = 4'b1000;
        j   = {8'hF0, 8'h00, 8'h00, 8'h00};
        k   = '0;
        tick();
        chk("t5_gnt", {28'd0, gnt}, 32'h8);
        req = 4'b0000;
        tick();
        chk("t5_abort", {31'd0, abort}, 32'h1);
        chk("t5_gnt_off", {28'd0, gnt}, 32'h0);
        chk("t5_q", {24'd0, q}, 32'h0F);
        chk("t5_cnt", {16'd0, apply_cnt}, 32'h4);
        chk("t5_last", {30'd0, last_id}, 32'h3);
        tick();
        chk("t5_abort_end", {31'd0, abort}, 32'h0);
        req = 4'b1001;
        j   = {8'hF0, 8'h00, 8'h00, 8'h00};
        k   = {8'h00, 8'h00, 8'h00, 8'h0F};
        tick();
        chk("t5_rr_lane0", {28'd0, gnt}, 32'h1);
        tick();
        chk("t5_rr_lane3", {28'd0, gnt}, 32'h8);
        chk("t5_q_mid", {24'd0, q}, 32'h00);
        req[0] = 1'b0;
        tick();
        req = 4'b0000;
        chk("t5_q_end", {24'd0, q}, 32'hF0);
        chk("t5_cnt_end", {16'd0, apply_cnt}, 32'h6);

        // 6a: reset mid-GRANT discards the command immediately
        req = 4'b0010;
        j   = {8'h00, 8'h00, 8'hAA, 8'h00};
        k   = '0;
        tick();
        chk("t6_gnt", {28'd0, gnt}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_q", {24'd0, q}, 32'h00);
        chk("t6_rst_gnt", {28'd0, gnt}, 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'h0);
        chk("t6_rst_cnt", {16'd0, apply_cnt}, 32'h0);
        req = 4'b0000;
        #1 rst_n = 1'b1;
        tick();
        chk("t6_post_q", {24'd0, q}, 32'h00);

        // 6b: counter saturation
        force dut.apply_cnt_q = 16'hFFFF;
        #1;
        release dut.apply_cnt_q;
        #1;
        chk("t6_cnt_forced", {16'd0, apply_cnt}, 32'hFFFF);
        req = 4'b0010;
        j   = {8'h00, 8'h00, 8'h01, 8'h00};
        k   = '0;
        tick();
        tick();
        req = 4'b0000;
        chk("t6_sat_q", {24'd0, q}, 32'h01);
        chk("t6_sat_cnt", {16'd0, apply_cnt}, 32'hFFFF);

        // single lane held continuously, X on an idle lane
        req = 4'b0100;
        j   = {8'h00, 8'h80, 8'h00, 8'hxx};
        k   = {8'h00, 8'h00, 8'h00, 8'hxx};
        tick();
        chk("t7_gnt_a", {28'd0, gnt}, 32'h4);
        tick();
        chk("t7_gap", {28'd0, gnt}, 32'h0);
        chk("t7_q", {24'd0, q}, 32'h81);
        tick();
        chk("t7_gnt_b", {28'd0, gnt}, 32'h4);
        tick();
        req = 4'b0000;
        j   = '0;
        k   = '0;
        chk("t7_q_end", {24'd0, q}, 32'h81);
        chk("t7_cnt", {16'd0, apply_cnt}, 32'hFFFF);
        chk("t7_last", {30'd0, last_id}, 32'h2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
